// File: rtl/seg_i2c_sequencer_if.sv
// seg_i2c_sequencer_if
// Purpose: groups the signals between the sequencer and the my_i2c atomic engine.
// Signals:
//   i2c_atomic  - atomic operation code presented to the engine
//   transaction - held high from START issue until STOP issue
//   slave_addr  - 7-bit device address
//   rd_wr       - transfer direction (0 = write)
//   data_out    - byte for the current WRITE
//   i2c_ready   - engine ready / operation-complete indication
// Modports: master (sequencer side), slave (engine side).
interface seg_i2c_sequencer_if;
  logic [7:0] i2c_atomic;
  logic       transaction;
  logic [6:0] slave_addr;
  logic       rd_wr;
  logic [7:0] data_out;
  logic       i2c_ready;

  modport master (
    output i2c_atomic, transaction, slave_addr, rd_wr, data_out,
    input  i2c_ready
  );

  modport slave (
    input  i2c_atomic, transaction, slave_addr, rd_wr, data_out,
    output i2c_ready
  );
endinterface

// File: rtl/seg_i2c_sequencer.sv
// seg_i2c_sequencer
// Purpose: turns a segment buffer and a brightness value into complete I2C
// frames (START, WRITE bytes, STOP) for an HT16K33-style LED controller,
// issuing one atomic operation at a time to the my_i2c engine.
// Ports:
//   clk, reset  - system clock, asynchronous active-high reset
//   enable      - engine enable; handshakes only advance while high
//   segs        - segment byte per digit, digit 0 in segs[7:0]
//   update      - pulse requesting a display RAM refresh frame
//   brightness  - dimming level 0..15
//   reinit      - pulse re-running the initialisation frames
//   bus         - engine-side interface (master modport)
//   busy        - a frame is in progress
//   done        - one-cycle pulse after a RAM frame completes
//   err         - sticky timeout flag, cleared by reinit or reset
// Optional feature: define SEG_AUTO_REFRESH_EN to build a free-running counter
// that requests a RAM frame every REFRESH_CYCLES cycles.
module seg_i2c_sequencer #(
  parameter int         NUM_DIGITS     = 4,
  parameter logic [6:0] DEV_ADDR       = 7'h70,
  parameter int         TIMEOUT_CYCLES = 65535,
  parameter int         REFRESH_CYCLES = 2_700_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [8*NUM_DIGITS-1:0] segs,
  input  logic                    update,
  input  logic [3:0]              brightness,
  input  logic                    reinit,
  seg_i2c_sequencer_if.master     bus,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);

  // my_i2c atomic operation codes
  localparam logic [7:0] MY_I2C_IDLE  = 8'h00;
  localparam logic [7:0] MY_I2C_START = 8'h01;
  localparam logic [7:0] MY_I2C_WRITE = 8'h02;
  localparam logic [7:0] MY_I2C_STOP  = 8'h04;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_SELECT    = 3'd1;
  localparam logic [2:0] S_ISSUE     = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_FINISH    = 3'd4;

  // Init frames are numbered so that the init index maps straight onto them
  localparam logic [1:0] F_OSC  = 2'd0;
  localparam logic [1:0] F_DISP = 2'd1;
  localparam logic [1:0] F_DIM  = 2'd2;
  localparam logic [1:0] F_RAM  = 2'd3;

  localparam logic [4:0] LAST_RAM   = 5'(2 + 2 * NUM_DIGITS);
  localparam logic [4:0] LAST_SHORT = 5'd2;

  logic [2:0]              r_state;
  logic [1:0]              r_frame;
  logic                    r_isInit;
  logic                    r_abort;
  logic [4:0]              r_stepIdx;
  logic [4:0]              r_lastStep;
  logic [15:0]             r_timer;
  logic [8*NUM_DIGITS-1:0] r_segs;
  logic                    r_initPend;
  logic [1:0]              r_initIdx;
  logic                    r_reinitHit;
  logic                    r_ramPend;
  logic [3:0]              r_lastBright;
  logic [7:0]              r_atomic;
  logic                    r_trans;
  logic [7:0]              r_data;
  logic                    r_busy;
  logic                    r_done;
  logic                    r_err;

  logic                    w_dimPend;
  logic                    w_anyPend;
  logic [1:0]              w_pickFrame;
  logic [4:0]              w_ramIdx;
  logic [8*NUM_DIGITS-1:0] w_segShift;
  logic [7:0]              w_writeByte;
  logic                    w_refreshTick;
  logic                    w_lastOp;

  assign bus.i2c_atomic  = r_atomic;
  assign bus.transaction = r_trans;
  assign bus.slave_addr  = DEV_ADDR;
  assign bus.rd_wr       = 1'b0;
  assign bus.data_out    = r_data;
  assign busy            = r_busy;
  assign done            = r_done;
  assign err             = r_err;

`ifdef SEG_AUTO_REFRESH_EN
  logic [31:0] r_refreshCnt;

  // Free-running refresh period counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_refreshCnt <= 32'(REFRESH_CYCLES - 1);
    end else if (r_refreshCnt == 32'd0) begin
      r_refreshCnt <= 32'(REFRESH_CYCLES - 1);
    end else begin
      r_refreshCnt <= r_refreshCnt - 32'd1;
    end
  end

  assign w_refreshTick = (r_refreshCnt == 32'd0);
`else
  logic w_unusedRefresh;
  assign w_unusedRefresh = |32'(REFRESH_CYCLES);
  assign w_refreshTick   = 1'b0;
`endif

  assign w_dimPend = (brightness != r_lastBright);
  assign w_anyPend = r_initPend | w_dimPend | r_ramPend;
  assign w_lastOp  = r_abort || (r_stepIdx == r_lastStep);

  // RAM payload after the address byte alternates seg byte / 0x00 per digit
  assign w_ramIdx   = r_stepIdx - 5'd2;
  assign w_segShift = r_segs >> {w_ramIdx[4:1], 3'b000};

  // Frame priority: init sequence, then a brightness change, then RAM
  always_comb begin
    w_pickFrame = F_RAM;
    if (r_initPend) begin
      w_pickFrame = r_initIdx;
    end else if (w_dimPend) begin
      w_pickFrame = F_DIM;
    end
  end

  // Byte for the current WRITE step
  always_comb begin
    w_writeByte = 8'h00;
    case (r_frame)
      F_OSC:   w_writeByte = 8'h21;
      F_DISP:  w_writeByte = 8'h81;
      F_DIM:   w_writeByte = {4'hE, brightness};
      default: w_writeByte = (r_stepIdx == 5'd1 || w_ramIdx[0]) ? 8'h00 : w_segShift[7:0];
    endcase
  end

  // Frame sequencer: one atomic op per SELECT/ISSUE/WAIT_DONE round
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_frame      <= F_OSC;
      r_isInit     <= 1'b0;
      r_abort      <= 1'b0;
      r_stepIdx    <= 5'd0;
      r_lastStep   <= LAST_SHORT;
      r_timer      <= 16'd0;
      r_segs       <= '0;
      r_initPend   <= 1'b1;
      r_initIdx    <= 2'd0;
      r_reinitHit  <= 1'b0;
      r_ramPend    <= 1'b0;
      r_lastBright <= 4'd0;
      r_atomic     <= MY_I2C_IDLE;
      r_trans      <= 1'b0;
      r_data       <= 8'h00;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_atomic <= MY_I2C_IDLE;
          if (w_anyPend) begin
            r_frame    <= w_pickFrame;
            r_isInit   <= r_initPend;
            r_abort    <= 1'b0;
            r_stepIdx  <= 5'd0;
            r_lastStep <= (w_pickFrame == F_RAM) ? LAST_RAM : LAST_SHORT;
            r_busy     <= 1'b1;
            r_state    <= S_SELECT;
            // RAM pending drops here so updates arriving mid-frame queue one more frame
            if (w_pickFrame == F_RAM) begin
              r_segs    <= segs;
              r_ramPend <= 1'b0;
            end
          end
        end
        S_SELECT: begin
          if (r_stepIdx == 5'd0) begin
            r_atomic <= MY_I2C_START;
            r_trans  <= 1'b1;
          end else if (r_stepIdx == r_lastStep) begin
            r_atomic <= MY_I2C_STOP;
            r_trans  <= 1'b0;
          end else begin
            r_atomic <= MY_I2C_WRITE;
            r_data   <= w_writeByte;
            if (r_frame == F_DIM) begin
              r_lastBright <= brightness;
            end
          end
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (enable && bus.i2c_ready) begin
            r_atomic <= MY_I2C_IDLE;
            r_timer  <= 16'(TIMEOUT_CYCLES);
            r_state  <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (enable && bus.i2c_ready) begin
            if (w_lastOp) begin
              r_state <= S_FINISH;
            end else begin
              r_stepIdx <= r_stepIdx + 5'd1;
              r_state   <= S_SELECT;
            end
          end else if (r_timer == 16'd0) begin
            // Timeout: flag it and close the bus with a single STOP
            r_err <= 1'b1;
            if (r_frame == F_DIM) begin
              r_lastBright <= brightness;
            end
            if (w_lastOp) begin
              r_state <= S_FINISH;
            end else begin
              r_abort  <= 1'b1;
              r_atomic <= MY_I2C_STOP;
              r_trans  <= 1'b0;
              r_state  <= S_ISSUE;
            end
          end else begin
            r_timer <= r_timer - 16'd1;
          end
        end
        S_FINISH: begin
          r_busy      <= 1'b0;
          r_done      <= (r_frame == F_RAM) && !r_abort;
          r_reinitHit <= 1'b0;
          // A reinit seen during an init frame restarts from OSC instead of advancing
          if (r_isInit && !r_reinitHit) begin
            if (r_initIdx == F_DIM) begin
              r_initPend <= 1'b0;
              r_initIdx  <= F_OSC;
            end else begin
              r_initIdx <= r_initIdx + 2'd1;
            end
          end
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase

      if (update || w_refreshTick) begin
        r_ramPend <= 1'b1;
      end
      if (reinit) begin
        r_initPend <= 1'b1;
        r_initIdx  <= F_OSC;
        r_err      <= 1'b0;
        if (r_state != S_IDLE || w_anyPend) begin
          r_reinitHit <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seg_i2c_sequencer.sv
// tb_seg_i2c_sequencer
// Directed bench for seg_i2c_sequencer with a behavioural my_i2c engine model
// that drops ready for 20 cycles after each consumed op (150 after a WRITE
// while holdArm is set). Every consumed op is logged as {code, data, trans}.
module tb_seg_i2c_sequencer;

  localparam logic [7:0] C_IDLE  = 8'h00;
  localparam logic [7:0] C_START = 8'h01;
  localparam logic [7:0] C_WRITE = 8'h02;
  localparam logic [7:0] C_STOP  = 8'h04;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [31:0] segs;
  logic        update;
  logic [3:0]  brightness;
  logic        reinit;
  logic        busy;
  logic        done;
  logic        err;

  int checks;
  int errors;

  seg_i2c_sequencer_if bus ();

  seg_i2c_sequencer #(
    .NUM_DIGITS    (4),
    .DEV_ADDR      (7'h70),
    .TIMEOUT_CYCLES(100),
    .REFRESH_CYCLES(2_700_000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .segs      (segs),
    .update    (update),
    .brightness(brightness),
    .reinit    (reinit),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Engine model and op log
  logic        engReady;
  int          engCnt;
  logic        holdArm;
  logic [16:0] opLog [$];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      engReady <= 1'b1;
      engCnt   <= 0;
    end else if (engReady && enable && bus.i2c_atomic != C_IDLE) begin
      opLog.push_back({bus.i2c_atomic, bus.data_out, bus.transaction});
      engReady <= 1'b0;
      engCnt   <= (holdArm && bus.i2c_atomic == C_WRITE) ? 150 : 20;
    end else if (!engReady) begin
      if (engCnt <= 1) engReady <= 1'b1;
      else engCnt <= engCnt - 1;
    end
  end

  assign bus.i2c_ready = engReady;

  // done pulse counting and width tracking
  int doneCount = 0;
  int doneRun   = 0;
  int doneMax   = 0;
  always @(posedge clk) begin
    if (done) begin
      doneCount = doneCount + 1;
      doneRun   = doneRun + 1;
      if (doneRun > doneMax) doneMax = doneRun;
    end else begin
      doneRun = 0;
    end
  end

  task automatic waitOps(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (opLog.size() >= n) break;
      @(negedge clk);
    end
    ok = (opLog.size() >= n);
  endtask

  task automatic pulseUpdate();
    @(negedge clk);
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
  endtask

  task automatic test_reset();
    bit ok;
    logic [15:0] exp [9] = '{16'h0100, 16'h0221, 16'h0400,
                             16'h0100, 16'h0281, 16'h0400,
                             16'h0100, 16'h02E0, 16'h0400};
    int d0;
    reset = 1'b0;
    #1 reset = 1'b1;
    #2;
    checks++; if (bus.i2c_atomic !== C_IDLE) begin errors++; $display("[TB] FAIL rst_atomic got %h want %h", bus.i2c_atomic, C_IDLE); end
    checks++; if (bus.transaction !== 1'b0) begin errors++; $display("[TB] FAIL rst_trans got %b want 0", bus.transaction); end
    checks++; if (bus.data_out !== 8'h00) begin errors++; $display("[TB] FAIL rst_data got %h want 00", bus.data_out); end
    checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("[TB] FAIL rst_flags got %b want 000", {busy, done, err}); end
    checks++; if (bus.slave_addr !== 7'h70 || bus.rd_wr !== 1'b0) begin errors++; $display("[TB] FAIL rst_addr got %h/%b want 70/0", bus.slave_addr, bus.rd_wr); end
    d0 = doneCount;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    waitOps(9, 2000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL init_timeout got %0d ops want 9", opLog.size()); end
    repeat (60) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      logic [16:0] o;
      o = (i < opLog.size()) ? opLog[i] : 17'h1FFFF;
      checks++;
      if (o[16:9] !== exp[i][15:8] || (o[16:9] == C_WRITE && o[8:1] !== exp[i][7:0]) || o[0] !== (exp[i][15:8] != C_STOP)) begin
        errors++; $display("[TB] FAIL init_op%0d got %h want %h", i, o, exp[i]);
      end
    end
    checks++; if (opLog.size() !== 9) begin errors++; $display("[TB] FAIL init_count got %0d want 9", opLog.size()); end
    checks++; if (doneCount !== d0) begin errors++; $display("[TB] FAIL init_done got %0d want %0d", doneCount, d0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL init_busy got %b want 0", busy); end
  endtask

  task automatic test_ram();
    bit ok;
    int base;
    int d0;
    logic [15:0] exp [11] = '{16'h0100, 16'h0200, 16'h024F, 16'h0200, 16'h025B, 16'h0200,
                              16'h0206, 16'h0200, 16'h023F, 16'h0200, 16'h0400};
    base = opLog.size();
    d0 = doneCount;
    segs = 32'h3F06_5B4F;
    pulseUpdate();
    waitOps(base + 1, 200, ok);
    segs = 32'hFFFF_FFFF;
    checks++; if (busy !== 1'b1) begin errors++; $display("[TB] FAIL ram_busy got %b want 1", busy); end
    waitOps(base + 11, 2000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL ram_timeout got %0d ops want %0d", opLog.size(), base + 11); end
    repeat (60) @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      logic [16:0] o;
      o = (base + i < opLog.size()) ? opLog[base + i] : 17'h1FFFF;
      checks++;
      if (o[16:9] !== exp[i][15:8] || (o[16:9] == C_WRITE && o[8:1] !== exp[i][7:0]) || o[0] !== (exp[i][15:8] != C_STOP)) begin
        errors++; $display("[TB] FAIL ram_op%0d got %h want %h", i, o, exp[i]);
      end
    end
    checks++; if (doneCount !== d0 + 1) begin errors++; $display("[TB] FAIL ram_done got %0d want %0d", doneCount, d0 + 1); end
    checks++; if (doneMax !== 1) begin errors++; $display("[TB] FAIL ram_donewidth got %0d want 1", doneMax); end
    checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL ram_idle_busy got %b want 0", busy); end
  endtask

  task automatic test_dim_then_ram();
    bit ok;
    int base;
    int d0;
    logic [15:0] exp [14] = '{16'h0100, 16'h02E9, 16'h0400,
                              16'h0100, 16'h0200, 16'h0278, 16'h0200, 16'h0256, 16'h0200,
                              16'h0234, 16'h0200, 16'h0212, 16'h0200, 16'h0400};
    base = opLog.size();
    d0 = doneCount;
    segs = 32'h1234_5678;
    @(negedge clk);
    brightness = 4'd9;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    waitOps(base + 14, 3000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL dimram_timeout got %0d ops want %0d", opLog.size(), base + 14); end
    repeat (60) @(negedge clk);
    for (int i = 0; i < 14; i++) begin
      logic [16:0] o;
      o = (base + i < opLog.size()) ? opLog[base + i] : 17'h1FFFF;
      checks++;
      if (o[16:9] !== exp[i][15:8] || (o[16:9] == C_WRITE && o[8:1] !== exp[i][7:0]) || o[0] !== (exp[i][15:8] != C_STOP)) begin
        errors++; $display("[TB] FAIL dimram_op%0d got %h want %h", i, o, exp[i]);
      end
    end
    checks++; if (opLog.size() !== base + 14) begin errors++; $display("[TB] FAIL dimram_count got %0d want %0d", opLog.size(), base + 14); end
    checks++; if (doneCount !== d0 + 1) begin errors++; $display("[TB] FAIL dimram_done got %0d want %0d", doneCount, d0 + 1); end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    int d0;
    base = opLog.size();
    d0 = doneCount;
    pulseUpdate();
    waitOps(base + 1, 200, ok);
    repeat (3) begin
      repeat (10) @(negedge clk);
      pulseUpdate();
    end
    waitOps(base + 22, 4000, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_timeout got %0d ops want %0d", opLog.size(), base + 22); end
    repeat (150) @(negedge clk);
    checks++; if (opLog.size() !== base + 22) begin errors++; $display("[TB] FAIL b2b_count got %0d want %0d", opLog.size(), base + 22); end
    checks++;
    if (base + 11 >= opLog.size() || opLog[base + 11][16:9] !== C_START) begin
      errors++; $display("[TB] FAIL b2b_second_start got size %0d want START at %0d", opLog.size(), base + 11);
    end
    checks++; if (doneCount !== d0 + 2) begin errors++; $display("[TB] FAIL b2b_done got %0d want %0d", doneCount, d0 + 2); end
  endtask

  task automatic test_timeout();
    bit ok;
    int base;
    int d0;
    logic [15:0] exp [9] = '{16'h0100, 16'h0221, 16'h0400,
                             16'h0100, 16'h0281, 16'h0400,
                             16'h0100, 16'h02E9, 16'h0400};
    base = opLog.size();
    d0 = doneCount;
    holdArm = 1'b1;
    pulseUpdate();
    waitOps(base + 2, 300, ok);
    checks++;
    if (!ok || opLog[base + 1][16:9] !== C_WRITE || opLog[base + 1][8:1] !== 8'h00) begin
      errors++; $display("[TB] FAIL to_write got size %0d want WRITE 00 at %0d", opLog.size(), base + 1);
    end
    repeat (50) @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_early got %b want 0", err); end
    repeat (60) @(negedge clk);
    checks++; if (err !== 1'b1) begin errors++; $display("[TB] FAIL to_err_set got %b want 1", err); end
    waitOps(base + 3, 300, ok);
    checks++;
    if (!ok || opLog[base + 2][16:9] !== C_STOP || opLog[base + 2][0] !== 1'b0) begin
      errors++; $display("[TB] FAIL to_stop got size %0d want STOP at %0d", opLog.size(), base + 2);
    end
    holdArm = 1'b0;
    repeat (60) @(negedge clk);
    checks++; if (opLog.size() !== base + 3) begin errors++; $display("[TB] FAIL to_count got %0d want %0d", opLog.size(), base + 3); end
    checks++; if (doneCount !== d0) begin errors++; $display("[TB] FAIL to_done got %0d want %0d", doneCount, d0); end
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("[TB] FAIL to_sticky got err %b busy %b want 1 0", err, busy); end
    @(negedge clk);
    reinit = 1'b1;
    @(negedge clk);
    reinit = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b0) begin errors++; $display("[TB] FAIL to_err_clear got %b want 0", err); end
    waitOps(base + 12, 2000, ok);
    repeat (60) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      logic [16:0] o;
      o = (base + 3 + i < opLog.size()) ? opLog[base + 3 + i] : 17'h1FFFF;
      checks++;
      if (o[16:9] !== exp[i][15:8] || (o[16:9] == C_WRITE && o[8:1] !== exp[i][7:0])) begin
        errors++; $display("[TB] FAIL reinit_op%0d got %h want %h", i, o, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    bit found;
    int base;
    int d0;
    logic [15:0] exp [9] = '{16'h0100, 16'h0221, 16'h0400,
                             16'h0100, 16'h0281, 16'h0400,
                             16'h0100, 16'h02E9, 16'h0400};
    base = opLog.size();
    pulseUpdate();
    waitOps(base + 3, 400, ok);
    found = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (bus.i2c_atomic != C_IDLE) begin
        found = 1'b1;
        break;
      end
    end
    checks++; if (!found || bus.transaction !== 1'b1) begin errors++; $display("[TB] FAIL mid_inframe got found %b trans %b want 1 1", found, bus.transaction); end
    #2 reset = 1'b1;
    #1;
    checks++; if (bus.i2c_atomic !== C_IDLE) begin errors++; $display("[TB] FAIL mid_atomic got %h want %h", bus.i2c_atomic, C_IDLE); end
    checks++; if (bus.transaction !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mid_trans got %b busy %b want 0 0", bus.transaction, busy); end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    base = opLog.size();
    d0 = doneCount;
    waitOps(base + 9, 2000, ok);
    repeat (60) @(negedge clk);
    for (int i = 0; i < 9; i++) begin
      logic [16:0] o;
      o = (base + i < opLog.size()) ? opLog[base + i] : 17'h1FFFF;
      checks++;
      if (o[16:9] !== exp[i][15:8] || (o[16:9] == C_WRITE && o[8:1] !== exp[i][7:0])) begin
        errors++; $display("[TB] FAIL mid_init_op%0d got %h want %h", i, o, exp[i]);
      end
    end
    checks++; if (opLog.size() !== base + 9 || doneCount !== d0) begin errors++; $display("[TB] FAIL mid_tail got %0d ops %0d done want %0d %0d", opLog.size(), doneCount, base + 9, d0); end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    enable     = 1'b1;
    segs       = 32'h0;
    update     = 1'b0;
    brightness = 4'd0;
    reinit     = 1'b0;
    holdArm    = 1'b0;
    test_reset();
    test_ram();
    test_dim_then_ram();
    test_back_to_back();
    test_timeout();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
